dmem_pipe: RTL
==============

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
- REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits (multiple of 8).
- REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two, 2..65536).
- REQ-003 SHALL have parameter ADDR_W, default 16, request address width (word-indexed).
- REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles (1..8).
- REQ-005 clk  input  1  sole clock; all state changes on rising edge.
- REQ-006 reset  input  1  synchronous, active-high reset.
- REQ-007 req_valid  input  1  request present.
- REQ-008 req_ready  output  1  request accepted when req_valid and req_ready are both high.
- REQ-009 mw  input  1  1 = write, 0 = read.
- REQ-010 addr  input  ADDR_W  word address.
- REQ-011 wd  input  DATA_W  write data.
- REQ-012 be  input  DATA_W/8  byte enables; bit k governs wd[8k+7:8k].
- REQ-013 rsp_valid  output  1  read data valid.
- REQ-014 rsp_ready  input  1  consumer accepts response.
- REQ-015 rd  output  DATA_W  read data.
- REQ-016 rsp_err  output  1  response flagged out-of-range (0 when DMEM_RANGE_CHECK_EN is not defined).

Function
- REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL equal (state == IDLE).
- REQ-018 Accepted write in IDLE SHALL update enabled bytes at that edge, leave disabled bytes unchanged, stay in IDLE, and produce no response.
- REQ-019 Accepted read SHALL capture addr, load a latency counter with RD_LAT-1, and go to WAIT (or straight to RESP when RD_LAT = 1).
- REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0; rsp_valid SHALL first assert exactly RD_LAT cycles after the accept edge.
- REQ-021 In RESP, rsp_valid, rd and rsp_err SHALL be held stable until rsp_valid && rsp_ready, then return to IDLE on that edge.
- REQ-022 Read data SHALL be sampled from the array when RESP is entered (writes cannot occur while busy, so no hazard exists).
- REQ-023 rd SHALL be 0 whenever rsp_valid is low.
- REQ-024 With range check disabled, the effective address SHALL be addr[$clog2(DEPTH)-1:0] (wrap-around modulo DEPTH).
- REQ-025 Memory contents SHALL be undefined until written; be = 0 writes SHALL be legal no-ops.

Reset
- REQ-026 On reset: state = IDLE, counter = 0, rsp_valid = 0, rd = 0, rsp_err = 0; req_ready SHALL be 1 in the first cycle after reset deasserts.
- REQ-027 Reset during WAIT or RESP SHALL discard the pending read with no response; reset SHALL NOT clear array contents.
- REQ-028 A request presented in the same cycle as reset SHALL be ignored.

Configuration
- REQ-029 When DMEM_RANGE_CHECK_EN is defined: addr >= DEPTH SHALL suppress writes and make reads respond with rd = 0, rsp_err = 1 at normal latency.
- REQ-030 When DMEM_RANGE_CHECK_EN is not defined: there SHALL be no comparison logic, rsp_err SHALL be tied to 0, and REQ-024 wrap-around SHALL apply.

Structure
- REQ-031 Package dmem_pkg SHALL hold the FSM state enum (dmem_state_t) and default parameter constants.
- REQ-032 Storage SHALL be a sub-module dmem_array (clk, we, waddr, wd, be, raddr, rd) with byte-enable write and a combinational read port.

Verification
- REQ-033 Write addr=0x000E, wd=0x000E, be=2'b11; read 0x000E -> rsp_valid RD_LAT cycles after accept, rd=0x000E.
- REQ-034 Write 0xABCD to 0x0003, then write 0x1200 with be=2'b10; read -> rd=0x12CD.
- REQ-035 RD_LAT=3: hold rsp_ready=0 for 4 cycles after rsp_valid -> rd stable, req_ready=0 throughout, back in IDLE one cycle after the handshake.
- REQ-036 Read 0x0040 with DEPTH=64: with DMEM_RANGE_CHECK_EN -> rd=0, rsp_err=1, and a prior write there leaves word 0 unchanged; without the macro -> aliases word 0x0000.
- REQ-037 Assert reset during WAIT -> no rsp_valid, req_ready=1 after release, previously written data at 0x000E still reads 0x000E.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and default parameters for the pipelined data memory
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_DEPTH  = 64;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_RD_LAT = 1;
    localparam int DMEM_CNT_W  = 3;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage with byte-enable write port and combinational read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    // byte lanes with a clear enable keep their previous contents
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < DATA_W/8; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wd[8*i +: 8];
    end

    assign rd = mem[raddr];

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: single-outstanding data memory with fixed read latency; optional DMEM_RANGE_CHECK_EN flags out-of-range accesses
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int RD_LAT = DMEM_RD_LAT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                mw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W/8-1:0] be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rd,
    output logic                rsp_err
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_t           state, state_nxt;
    logic [DMEM_CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]         raddr_q, raddr;
    logic [DATA_W-1:0]     arr_rd, rd_q;
    logic                  accept, rd_accept, we, load, in_range, rd_err;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rd        = rd_q;
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !mw;
    assign we        = accept && mw && !reset && in_range;
    assign raddr     = (state == IDLE) ? addr[AW-1:0] : raddr_q;

    dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (addr[AW-1:0]),
        .wd    (wd),
        .be    (be),
        .raddr (raddr),
        .rd    (arr_rd)
    );

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q, rsp_err_q;

    assign in_range = 64'(addr) < 64'(DEPTH);
    assign rd_err   = (state == IDLE) ? !in_range : err_q;
    assign rsp_err  = rsp_err_q;

    // remember whether the pending read was out of range and present it alongside the response
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (rd_accept) err_q <= !in_range;
            if (load) rsp_err_q <= rd_err;
            else if (rsp_valid && rsp_ready) rsp_err_q <= 1'b0;
        end
    end
`else
    logic addr_unused;

    assign addr_unused = ^addr;
    assign in_range    = 1'b1;
    assign rd_err      = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // next state: load the latency counter on a read accept, count down in WAIT, release on handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        unique case (state)
            IDLE: if (rd_accept) begin
                cnt_nxt   = DMEM_CNT_W'(RD_LAT - 1);
                state_nxt = (RD_LAT == 1) ? RESP : WAIT;
                load      = (RD_LAT == 1);
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= DMEM_CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                    load      = 1'b1;
                end
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, counter and captured read address; the array is sampled as RESP is entered and cleared on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            raddr_q <= '0;
            rd_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_accept) raddr_q <= addr[AW-1:0];
            if (load) rd_q <= rd_err ? '0 : arr_rd;
            else if (rsp_valid && rsp_ready) rd_q <= '0;
        end
    end

endmodule
